// File: rtl/neuron_pkg.sv
// Shared constants, config-select encodings and FSM state type for the Ising neuron array.
package neuron_pkg;

  localparam logic [1:0] SPK_NONE = 2'd0;
  localparam logic [1:0] SPK_POS  = 2'd1;
  localparam logic [1:0] SPK_NEG  = 2'd2;

  localparam logic [1:0] CFG_Q    = 2'd0;
  localparam logic [1:0] CFG_VMEM = 2'd1;
  localparam logic [1:0] CFG_ID   = 2'd2;
  localparam logic [1:0] CFG_MU   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT    = 3'd1,
    NETWORK = 3'd2,
    RECV    = 3'd3,
    SIGN    = 3'd4
  } state_t;

  // A firing neuron reports its spin: up spin -> NEG code, down spin -> POS code.
  function automatic logic [1:0] spike_code(input logic fire, input logic spin);
    if (!fire) return SPK_NONE;
    return spin ? SPK_NEG : SPK_POS;
  endfunction

endpackage

// File: rtl/neuron_lane.sv
// One Ising neuron lane: Q coupling RAM, membrane/threshold/spin state and update datapath.
// Optional threshold annealing is enabled with NEURON_MU_ANNEAL_EN.
module neuron_lane
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_NEURON      = 256,
  parameter int unsigned NEURON_ID_WIDTH = 8,
  parameter int unsigned VMEM_WIDTH      = 16,
  parameter int          STEP            = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       i_cfg_we,
  input  logic [1:0]                 i_cfg_sel,
  input  logic [NEURON_ID_WIDTH-1:0] i_cfg_addr,
  input  logic [VMEM_WIDTH-1:0]      i_cfg_data,
  input  logic                       i_rd_en,
  input  logic [NEURON_ID_WIDTH-1:0] i_rd_addr,
  input  logic                       i_upd_en,
  input  logic [1:0]                 i_upd_sign,
  input  logic [NEURON_ID_WIDTH-1:0] i_upd_id,
  input  logic                       i_emit,
  input  logic                       i_sign_upd,
  input  logic [VMEM_WIDTH-1:0]      i_mu_step,
  output logic [1:0]                 o_spike,
  output logic                       o_fire
);

  localparam int unsigned VW  = VMEM_WIDTH;
  localparam int unsigned IDW = NEURON_ID_WIDTH;
  localparam logic signed [VW-1:0] VMAX   = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] VMIN   = {1'b1, {(VW-1){1'b0}}};
  localparam logic signed [VW:0]   STEP_X = (VW+1)'(STEP);

  logic [1:0]           r_qram [NUM_NEURON];
  logic [1:0]           r_q;
  logic signed [VW-1:0] r_vmem;
  logic signed [VW-1:0] r_vmem_s;
  logic signed [VW-1:0] r_mu;
  logic [IDW-1:0]       r_id;
  logic                 r_spin;

  logic                 w_inc;
  logic                 w_dec;
  logic                 w_hit;
  logic                 w_fire;
  logic signed [VW:0]   w_sum;
  logic signed [VW-1:0] w_vmem_nxt;
  logic signed [VW-1:0] w_vs_src;
  logic signed [VW-1:0] w_vs;

  // Coupling RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && i_cfg_we && (i_cfg_sel == CFG_Q)) r_qram[i_cfg_addr] <= i_cfg_data[1:0];
  end

  always_comb begin
    w_inc = ((i_upd_sign == SPK_POS) && (r_q == SPK_POS)) ||
            ((i_upd_sign == SPK_NEG) && (r_q == SPK_NEG));
    w_dec = ((i_upd_sign == SPK_POS) && (r_q == SPK_NEG)) ||
            ((i_upd_sign == SPK_NEG) && (r_q == SPK_POS));
    w_sum = {r_vmem[VW-1], r_vmem};
    if (w_inc) w_sum = w_sum + STEP_X;
    else if (w_dec) w_sum = w_sum - STEP_X;
    // Overflow shows up as disagreement between the extension bit and the sign bit.
    if (w_sum[VW] != w_sum[VW-1]) w_vmem_nxt = w_sum[VW] ? VMIN : VMAX;
    else w_vmem_nxt = w_sum[VW-1:0];
    w_hit    = ((i_upd_sign == SPK_POS) || (i_upd_sign == SPK_NEG)) && (i_upd_id == r_id);
    w_fire   = (r_vmem_s > r_mu);
    w_vs_src = i_sign_upd ? r_vmem : $signed(i_cfg_data);
    if (r_spin) w_vs = w_vs_src;
    else if (w_vs_src == VMIN) w_vs = VMAX;
    else w_vs = VW'(-w_vs_src);
  end

`ifdef NEURON_MU_ANNEAL_EN
  logic r_emit_d;
`else
  logic w_unused_mu_step;
  assign w_unused_mu_step = ^i_mu_step;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= SPK_NONE;
      r_vmem   <= '0;
      r_vmem_s <= '0;
      r_mu     <= '0;
      r_id     <= '0;
      r_spin   <= 1'b1;
      o_spike  <= SPK_NONE;
      o_fire   <= 1'b0;
`ifdef NEURON_MU_ANNEAL_EN
      r_emit_d <= 1'b0;
`endif
    end else if (en) begin
      if (i_cfg_we) begin
        case (i_cfg_sel)
          CFG_VMEM: begin
            r_vmem   <= $signed(i_cfg_data);
            r_vmem_s <= w_vs;
          end
          CFG_ID:  r_id <= i_cfg_data[IDW-1:0];
          CFG_MU:  r_mu <= $signed(i_cfg_data);
          default: ;
        endcase
      end
      if (i_rd_en) r_q <= r_qram[i_rd_addr];
      if (i_upd_en) begin
        r_vmem <= w_vmem_nxt;
        if (w_hit) r_spin <= ~r_spin;
      end
      if (i_sign_upd) r_vmem_s <= w_vs;
      if (i_emit) begin
        o_fire  <= w_fire;
        o_spike <= spike_code(w_fire, r_spin);
      end
`ifdef NEURON_MU_ANNEAL_EN
      r_emit_d <= i_emit;
      if (r_emit_d) r_mu <= (r_mu > $signed(i_mu_step)) ? (r_mu - $signed(i_mu_step)) : '0;
`endif
    end
  end

endmodule

// File: rtl/neuron_array.sv
// Annealing loop controller with NUM_LANES parallel Ising neuron lanes.
// Lane threshold annealing is enabled with NEURON_MU_ANNEAL_EN.
module neuron_array
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned NUM_NEURON      = 256,
  parameter int unsigned NEURON_ID_WIDTH = 8,
  parameter int unsigned VMEM_WIDTH      = 16,
  parameter int          STEP            = 2,
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [1:0]                 cfg_sel,
  input  logic [LANE_W-1:0]          cfg_lane,
  input  logic [NEURON_ID_WIDTH-1:0] cfg_addr,
  input  logic [VMEM_WIDTH-1:0]      cfg_data,
  input  logic                       spk_valid,
  output logic                       spk_ready,
  input  logic [1:0]                 spk_sign,
  input  logic [NEURON_ID_WIDTH-1:0] spk_id,
  input  logic                       run,
  output logic                       net_req,
  input  logic                       net_done,
  output logic [2*NUM_LANES-1:0]     spike_out,
  output logic [NUM_LANES-1:0]       fire_out,
  input  logic [VMEM_WIDTH-1:0]      mu_step
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_cfg_beat;
  logic                       w_spk_beat;
  logic                       w_emit;
  logic                       w_sign;
  logic                       r_pipe_v;
  logic [1:0]                 r_pipe_sign;
  logic [NEURON_ID_WIDTH-1:0] r_pipe_id;

  // Handshakes are qualified by en so they read 0 while frozen.
  assign cfg_ready  = en && (r_state == IDLE);
  assign spk_ready  = en && (r_state == RECV);
  assign net_req    = en && (r_state == NETWORK);
  assign w_cfg_beat = cfg_valid && cfg_ready;
  assign w_spk_beat = spk_valid && spk_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else if (en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_sign      = 1'b0;
    case (r_state)
      IDLE:    if (run && !w_cfg_beat) w_state_nxt = EMIT;
      EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = NETWORK;
      end
      NETWORK: if (net_done) w_state_nxt = RECV;
      // Leave only once the last accepted spike has been applied.
      RECV:    if (!spk_valid && !r_pipe_v) w_state_nxt = SIGN;
      SIGN: begin
        w_sign      = 1'b1;
        w_state_nxt = run ? EMIT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Second stage of the spike pipeline, aligned with the registered Q read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_v    <= 1'b0;
      r_pipe_sign <= SPK_NONE;
      r_pipe_id   <= '0;
    end else if (en) begin
      r_pipe_v    <= w_spk_beat;
      r_pipe_sign <= spk_sign;
      r_pipe_id   <= spk_id;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    neuron_lane #(
      .NUM_NEURON      (NUM_NEURON),
      .NEURON_ID_WIDTH (NEURON_ID_WIDTH),
      .VMEM_WIDTH      (VMEM_WIDTH),
      .STEP            (STEP)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .i_cfg_we   (w_cfg_beat && (cfg_lane == LANE_W'(g))),
      .i_cfg_sel  (cfg_sel),
      .i_cfg_addr (cfg_addr),
      .i_cfg_data (cfg_data),
      .i_rd_en    (w_spk_beat),
      .i_rd_addr  (spk_id),
      .i_upd_en   (r_pipe_v),
      .i_upd_sign (r_pipe_sign),
      .i_upd_id   (r_pipe_id),
      .i_emit     (w_emit),
      .i_sign_upd (w_sign),
      .i_mu_step  (mu_step),
      .o_spike    (spike_out[2*g +: 2]),
      .o_fire     (fire_out[g])
    );
  end

endmodule

// File: tb/tb_neuron_array.sv
// Directed, table-driven bench for neuron_array; observes neuron state through EMIT results.
// Threshold-annealing checks follow NEURON_MU_ANNEAL_EN.
module tb_neuron_array;
  import neuron_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_sel;
  logic [1:0]  cfg_lane;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        spk_valid;
  logic        spk_ready;
  logic [1:0]  spk_sign;
  logic [7:0]  spk_id;
  logic        run;
  logic        net_req;
  logic        net_done;
  logic [7:0]  spike_out;
  logic [3:0]  fire_out;
  logic [15:0] mu_step;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] sg  [8];
  logic [7:0] sid [8];

  typedef struct {
    int                 lane;
    logic signed [15:0] vmem;
    logic signed [15:0] mu;
    logic [1:0]         code;
    logic               fire;
  } vec_t;

  vec_t tbl [6];

  neuron_array dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_lane  (cfg_lane),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_sign  (spk_sign),
    .spk_id    (spk_id),
    .run       (run),
    .net_req   (net_req),
    .net_done  (net_done),
    .spike_out (spike_out),
    .fire_out  (fire_out),
    .mu_step   (mu_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input int l);
    return spike_out[2*l +: 2];
  endfunction

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] lane,
                           input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_lane  = lane;
    cfg_addr  = addr;
    cfg_data  = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // One annealing pass: EMIT, network handshake, n spikes from sg/sid, back to IDLE.
  task automatic run_loop(input int n, input bit glitch);
    int k;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    k = 0;
    while (!net_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("net_req_up", 32'(net_req), 32'd1);
    if (glitch) begin
      en       = 1'b0;
      net_done = 1'b1;
      #1;
      chk("net_req_en_low", 32'(net_req), 32'd0);
      chk("cfg_ready_en_low", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      en       = 1'b1;
      net_done = 1'b0;
      #1;
      chk("net_req_held", 32'(net_req), 32'd1);
    end
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
    chk("net_req_drop", 32'(net_req), 32'd0);
    chk("spk_ready", 32'(spk_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      spk_valid = 1'b1;
      spk_sign  = sg[i];
      spk_id    = sid[i];
      @(negedge clk);
    end
    spk_valid = 1'b0;
    k = 0;
    while (!cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("back_to_idle", 32'(cfg_ready), 32'd1);
  endtask

  task automatic probe(input string nm, input int lane, input logic [15:0] mu,
                       input logic exp_fire);
    cfg_write(CFG_MU, 2'(lane), 8'd0, mu);
    run_loop(0, 1'b0);
    chk(nm, 32'(fire_out[lane]), 32'(exp_fire));
  endtask

  initial begin
    tbl[0] = '{0, 16'sd5,     16'sd3,      2'd2, 1'b1};
    tbl[1] = '{1, 16'sd3,     16'sd3,      2'd0, 1'b0};
    tbl[2] = '{2, -16'sd1,    -16'sd2,     2'd2, 1'b1};
    tbl[3] = '{3, -16'sd5,    16'sd0,      2'd0, 1'b0};
    tbl[4] = '{0, 16'sd32767, 16'sh8000,   2'd2, 1'b1};
    tbl[5] = '{1, 16'sd0,     16'sd0,      2'd0, 1'b0};

    reset = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_lane = '0;
    cfg_addr = '0; cfg_data = '0; spk_valid = 1'b0; spk_sign = '0; spk_id = '0;
    run = 1'b0; net_done = 1'b0; mu_step = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_net_req", 32'(net_req), 32'd0);
    chk("rst_spk_ready", 32'(spk_ready), 32'd0);
    chk("rst_spike_out", 32'(spike_out), 32'd0);
    chk("rst_fire_out", 32'(fire_out), 32'd0);

    // Threshold compare, sign of fire code, signed boundaries
    for (int i = 0; i < 6; i++) begin
      cfg_write(CFG_VMEM, 2'(tbl[i].lane), 8'd0, tbl[i].vmem);
      cfg_write(CFG_MU, 2'(tbl[i].lane), 8'd0, tbl[i].mu);
      run_loop(0, 1'b0);
      chk($sformatf("tbl%0d_code", i), 32'(code_of(tbl[i].lane)), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_fire", i), 32'(fire_out[tbl[i].lane]), 32'(tbl[i].fire));
    end

    // en low: cfg writes ignored, NETWORK frozen even with net_done high
    en = 1'b0;
    #1;
    chk("cfg_ready_en0", 32'(cfg_ready), 32'd0);
    cfg_write(CFG_MU, 2'd0, 8'd0, 16'sd32767);
    en = 1'b1;
    run_loop(0, 1'b1);
    chk("en0_cfg_ignored", 32'(fire_out[0]), 32'd1);

    // Coupled spikes on lane 1: +2 then back to 0
    cfg_write(CFG_Q, 2'd1, 8'd7, 16'd1);
    cfg_write(CFG_VMEM, 2'd1, 8'd0, 16'd0);
    sg[0] = SPK_POS; sid[0] = 8'd7;
    run_loop(1, 1'b0);
    probe("l1_vmem2_gt1", 1, 16'sd1, 1'b1);
    probe("l1_vmem2_gt2", 1, 16'sd2, 1'b0);
    sg[0] = SPK_NEG; sid[0] = 8'd7;
    run_loop(1, 1'b0);
    probe("l1_vmem0_gtm1", 1, -16'sd1, 1'b1);
    probe("l1_vmem0_gt0", 1, 16'sd0, 1'b0);

    // Saturation on lane 2 with back-to-back spikes, then negation with spin down
    cfg_write(CFG_Q, 2'd2, 8'd3, 16'd1);
    cfg_write(CFG_VMEM, 2'd2, 8'd0, 16'sd32766);
    sg[0] = SPK_POS; sid[0] = 8'd3;
    sg[1] = SPK_POS; sid[1] = 8'd3;
    run_loop(2, 1'b0);
    probe("l2_sat_max", 2, 16'sd32766, 1'b1);
    chk("l2_sat_code", 32'(code_of(2)), 32'd2);
    cfg_write(CFG_Q, 2'd2, 8'd5, 16'd0);
    cfg_write(CFG_ID, 2'd2, 8'd0, 16'd5);
    sg[0] = SPK_POS; sid[0] = 8'd5;
    run_loop(1, 1'b0);
    cfg_write(CFG_VMEM, 2'd2, 8'd0, -16'sd32767);
    probe("l2_neg_m32767", 2, 16'sd32766, 1'b1);
    chk("l2_spin0_code", 32'(code_of(2)), 32'd1);
    cfg_write(CFG_VMEM, 2'd2, 8'd0, 16'sh8000);
    run_loop(0, 1'b0);
    chk("l2_neg_min_sat", 32'(fire_out[2]), 32'd1);

    // Spin toggling on lane 3: a +/- pair cancels, a single spike flips
    cfg_write(CFG_Q, 2'd3, 8'd9, 16'd0);
    cfg_write(CFG_ID, 2'd3, 8'd0, 16'd9);
    cfg_write(CFG_VMEM, 2'd3, 8'd0, 16'sd10);
    cfg_write(CFG_MU, 2'd3, 8'd0, 16'sd0);
    sg[0] = SPK_POS; sid[0] = 8'd9;
    sg[1] = SPK_NEG; sid[1] = 8'd9;
    run_loop(2, 1'b0);
    run_loop(0, 1'b0);
    chk("l3_pair_code", 32'(code_of(3)), 32'd2);
    sg[0] = SPK_POS; sid[0] = 8'd9;
    run_loop(1, 1'b0);
    probe("l3_flip_fire", 3, -16'sd20, 1'b1);
    chk("l3_flip_code", 32'(code_of(3)), 32'd1);

    // Reset in NETWORK; Q-RAM survives
    cfg_write(CFG_Q, 2'd0, 8'd4, 16'd2);
    cfg_write(CFG_VMEM, 2'd0, 8'd0, 16'sd5);
    cfg_write(CFG_MU, 2'd0, 8'd0, 16'sd3);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("pre_rst_net_req", 32'(net_req), 32'd1);
    chk("pre_rst_code", 32'(code_of(0)), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_net_req", 32'(net_req), 32'd0);
    chk("mid_rst_idle", 32'(cfg_ready), 32'd1);
    chk("mid_rst_spike", 32'(spike_out), 32'd0);
    reset = 1'b0;
    cfg_write(CFG_MU, 2'd0, 8'd0, -16'sd3);
    sg[0] = SPK_NEG; sid[0] = 8'd4;
    run_loop(1, 1'b0);
    probe("qram_kept_gt1", 0, 16'sd1, 1'b1);
    probe("qram_kept_gt2", 0, 16'sd2, 1'b0);

    // Threshold behaviour across repeated EMITs
    mu_step = 16'd4;
`ifdef NEURON_MU_ANNEAL_EN
    cfg_write(CFG_VMEM, 2'd0, 8'd0, 16'sd7);
    cfg_write(CFG_MU, 2'd0, 8'd0, 16'sd10);
    run_loop(0, 1'b0);
    chk("anneal_mu10", 32'(fire_out[0]), 32'd0);
    run_loop(0, 1'b0);
    chk("anneal_mu6", 32'(fire_out[0]), 32'd1);
    run_loop(0, 1'b0);
    chk("anneal_mu2", 32'(fire_out[0]), 32'd1);
    cfg_write(CFG_VMEM, 2'd0, 8'd0, -16'sd1);
    run_loop(0, 1'b0);
    chk("anneal_mu0_floor", 32'(fire_out[0]), 32'd0);
`else
    cfg_write(CFG_VMEM, 2'd0, 8'd0, 16'sd5);
    cfg_write(CFG_MU, 2'd0, 8'd0, 16'sd3);
    for (int i = 0; i < 3; i++) begin
      run_loop(0, 1'b0);
      chk($sformatf("mu_fixed_emit%0d", i), 32'(fire_out[0]), 32'd1);
    end
    cfg_write(CFG_VMEM, 2'd0, 8'd0, 16'sd3);
    run_loop(0, 1'b0);
    chk("mu_step_ignored", 32'(fire_out[0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
